// File: rtl/pi_request_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pi_request_arbiter                                              |
// | Purpose  : Round-robin arbiter for asynchronous external request lines     |
// |            with an Avalon-MM register interface.                           |
// | Options  : define PI_REQ_TIMEOUT_EN to build the grant watchdog.           |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module pi_request_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [1:0]         address,
  input  logic               read,
  input  logic               write,
  input  logic [31:0]        writedata,
  output logic [31:0]        readdata,
  output logic               irq,
  input  logic [NUM_REQ-1:0] req_in,
  output logic [NUM_REQ-1:0] grant_out
);

  localparam int         IDX_W     = $clog2(NUM_REQ);
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_GRANT   = 2'd1;
  localparam logic [1:0] S_RELEASE = 2'd2;

  logic [SYNC_STAGES-1:0][NUM_REQ-1:0] r_sync;
  logic [NUM_REQ-1:0] r_req_d, w_req_s, w_rise, r_pending, w_pend_clr;
  logic [NUM_REQ-1:0] r_mask, w_elig, r_grant_out, w_grant_nxt;
  logic [1:0]         r_state, w_state_nxt;
  logic [IDX_W-1:0]   r_grant_idx, w_grant_idx_nxt, r_last_grant, w_pick, w_cand;
  logic               w_found, w_ack, w_timeout_hit, w_timeout_flag;
  logic               r_irq_en, r_irq, w_wr_ctrl, w_wr_mask;
  logic [31:0]        r_readdata, w_rd_mux, w_status;
  logic               w_unused_wd;

  if (NUM_REQ < 2 || NUM_REQ > 8 || SYNC_STAGES < 2 || SYNC_STAGES > 3 ||
      TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("pi_request_arbiter: parameter out of legal range");
  end

  assign w_unused_wd = ^writedata;
  assign w_req_s     = r_sync[SYNC_STAGES-1];
  assign w_rise      = w_req_s & ~r_req_d;
  assign w_elig      = r_pending & r_mask;
  assign w_ack       = write && (address == 2'd1) && writedata[0] && (r_state == S_GRANT);
  assign w_wr_mask   = write && (address == 2'd2);
  assign w_wr_ctrl   = write && (address == 2'd3);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync  <= '0;
      r_req_d <= '0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], req_in};
      r_req_d <= w_req_s;
    end
  end

  // Scan starts one past the last served channel, wrapping at NUM_REQ-1.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_cand  = r_last_grant;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand = (w_cand == IDX_W'(NUM_REQ - 1)) ? '0 : w_cand + IDX_W'(1);
      if (!w_found && w_elig[w_cand]) begin
        w_found = 1'b1;
        w_pick  = w_cand;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_found) w_state_nxt = S_GRANT;
      S_GRANT:   if (w_ack || w_timeout_hit) w_state_nxt = S_RELEASE;
      S_RELEASE: if (!w_req_s[r_grant_idx]) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_pend_clr      = '0;
    w_grant_nxt     = '0;
    w_grant_idx_nxt = r_grant_idx;
    if (r_state == S_IDLE && w_found) begin
      w_pend_clr[w_pick] = 1'b1;
      w_grant_idx_nxt    = w_pick;
    end
    if (w_state_nxt == S_GRANT) w_grant_nxt[w_grant_idx_nxt] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pending    <= '0;
      r_grant_idx  <= '0;
      r_last_grant <= IDX_W'(NUM_REQ - 1);
      r_grant_out  <= '0;
    end else begin
      r_pending   <= (r_pending & ~w_pend_clr) | w_rise;
      r_grant_idx <= w_grant_idx_nxt;
      r_grant_out <= w_grant_nxt;
      if (r_state == S_RELEASE && w_state_nxt == S_IDLE) r_last_grant <= r_grant_idx;
    end
  end

`ifdef PI_REQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CNT_W-1:0] r_wd_cnt;
  logic             r_timeout_flag;

  assign w_timeout_hit  = (r_state == S_GRANT) && (r_wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign w_timeout_flag = r_timeout_flag;

  // Counter is held at zero outside GRANT so each grant starts from a clean count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wd_cnt       <= '0;
      r_timeout_flag <= 1'b0;
    end else begin
      r_wd_cnt <= (r_state == S_GRANT) ? r_wd_cnt + CNT_W'(1) : '0;
      if (w_timeout_hit && !w_ack)         r_timeout_flag <= 1'b1;
      else if (w_wr_ctrl && writedata[1])  r_timeout_flag <= 1'b0;
    end
  end
`else
  assign w_timeout_hit  = 1'b0;
  assign w_timeout_flag = 1'b0;
`endif

  always_comb begin
    w_status                   = '0;
    w_status[0]                = (r_state == S_GRANT);
    w_status[1]                = w_timeout_flag;
    w_status[8 +: IDX_W]       = r_grant_idx;
    w_status[16 +: NUM_REQ]    = r_pending;
  end

  always_comb begin
    w_rd_mux = '0;
    case (address)
      2'd0:    w_rd_mux = w_status;
      2'd1:    w_rd_mux = '0;
      2'd2:    w_rd_mux[NUM_REQ-1:0] = r_mask;
      default: w_rd_mux[1:0] = {w_timeout_flag, r_irq_en};
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mask     <= '1;
      r_irq_en   <= 1'b0;
      r_irq      <= 1'b0;
      r_readdata <= '0;
    end else begin
      if (w_wr_mask) r_mask   <= writedata[NUM_REQ-1:0];
      if (w_wr_ctrl) r_irq_en <= writedata[0];
      if (read)      r_readdata <= w_rd_mux;
      r_irq <= r_irq_en & ((r_state == S_GRANT) | w_timeout_flag);
    end
  end

  assign readdata  = r_readdata;
  assign irq       = r_irq;
  assign grant_out = r_grant_out;

endmodule
`default_nettype wire

// File: doc/pi_request_arbiter.md
PI_REQUEST_ARBITER -- requirements
Module: pi_request_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, meaning number of external request lines (legal 2..8).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning synchronizer flops per request line (legal 2..3).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 50000, meaning grant watchdog limit in clk cycles (used only under REQ-030).
REQ-004 SHALL have port clk  input  1  system clock; all logic rising-edge.
REQ-005 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port address  input  2  Avalon-MM word address.
REQ-007 SHALL have port read  input  1  Avalon read strobe.
REQ-008 SHALL have port write  input  1  Avalon write strobe.
REQ-009 SHALL have port writedata  input  32  Avalon write data.
REQ-010 SHALL have port readdata  output  32  Avalon read data, registered.
REQ-011 SHALL have port irq  output  1  level interrupt to CPU.
REQ-012 SHALL have port req_in  input  NUM_REQ  asynchronous request lines from external host.
REQ-013 SHALL have port grant_out  output  NUM_REQ  one-hot grant back to external host, registered.

Function
REQ-014 SHALL pass each req_in bit through SYNC_STAGES flops, then rising-edge detect on the synchronized value.
REQ-015 SHALL set pending[i] on a detected rising edge of channel i; set wins over a same-cycle clear.
REQ-016 SHALL run FSM IDLE -> GRANT -> RELEASE -> IDLE.
REQ-017 IDLE: if (pending & mask) != 0, SHALL pick round-robin starting at index last_grant+1 (wrapping NUM_REQ-1 -> 0), clear that pending bit, load grant_idx, enter GRANT next cycle.
REQ-018 GRANT: grant_out SHALL be one-hot on grant_idx, zero in every other state.
REQ-019 GRANT -> RELEASE SHALL occur the cycle after a write to address 1 with writedata[0]=1; ACK writes outside GRANT SHALL be ignored.
REQ-020 RELEASE: SHALL wait until synchronized req_in[grant_idx]=0, then update last_grant=grant_idx and enter IDLE.
REQ-021 Register map, addr 0 STATUS (RO): bit0 = state==GRANT, bit1 = timeout_flag, bits[10:8] = grant_idx, bits[23:16] = pending (upper unused bits 0).
REQ-022 addr 1 ACK (WO): reads SHALL return 0.
REQ-023 addr 2 MASK (RW): bits[NUM_REQ-1:0]; masked channels still latch pending but are not granted.
REQ-024 addr 3 CTRL (RW bit0 irq_en); writing bit1=1 SHALL clear timeout_flag; read bit1 = timeout_flag.
REQ-025 readdata SHALL update on the clk edge where read=1 with 1-cycle latency; otherwise hold.
REQ-026 irq SHALL equal irq_en & ((state==GRANT) | timeout_flag), registered.
REQ-027 Simultaneous edges on several channels SHALL all latch; they are served one per GRANT in round-robin order.

Reset
REQ-028 On reset_n=0: state=IDLE, pending=0, mask=all ones, irq_en=0, timeout_flag=0, last_grant=NUM_REQ-1, grant_idx=0, sync flops=0, grant_out=0, irq=0, readdata=0.
REQ-029 Reset asserted mid-GRANT SHALL drop grant_out to 0 immediately (asynchronously) and discard all pending requests.

Configuration
REQ-030 With PI_REQ_TIMEOUT_EN defined: a counter SHALL clear on GRANT entry, increment each GRANT cycle; reaching TIMEOUT_CYCLES-1 SHALL force GRANT -> RELEASE and set timeout_flag; ACK on the same cycle takes precedence (no flag).
REQ-031 Without PI_REQ_TIMEOUT_EN: no counter is built, STATUS bit1 and CTRL bit1 read 0, GRANT persists until ACK.

Verification
REQ-032 Pulse req_in[2] high, leave high -> STATUS=0x0000_0201 after sync+2 cycles, grant_out=4'b0100.
REQ-033 In GRANT write addr1=0x1, drop req_in[2] -> grant_out=0 next cycle, STATUS bit0=0 after RELEASE, last_grant=2.
REQ-034 Raise req_in[0],[1],[3] in same cycle with last_grant=3 -> grants served 0,1,3 in order, each after ACK.
REQ-035 MASK=0xE, raise req_in[0] -> no grant, STATUS pending=0x01; then MASK=0xF -> grant idx 0.
REQ-036 PI_REQ_TIMEOUT_EN, TIMEOUT_CYCLES=16, irq_en=1, no ACK -> forced release at grant cycle 16, STATUS bit1=1, irq=1; write addr3=0x3 -> irq=0.
REQ-037 Assert reset_n=0 mid-GRANT -> grant_out=0 same cycle, all registers read per REQ-028 after release.
